// File: rtl/popcount_accum.sv
// popcount_accum: two-stage streaming population counter.
// Stage 1 compresses each accepted beat to its ones count and tags it with
// the effective mode and last flag. Stage 2 either presents the count
// directly (per-beat mode) or adds it into a saturating accumulator and
// presents the packet total on the last beat (accumulate mode).
// The whole pipeline stalls while a presented result is not taken.
module popcount_accum #(
    parameter int N     = 16,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_sat
);

    localparam int CNT_W = $clog2(N + 1);

    // Ones count of a beat; the loop unrolls into an adder/compressor tree.
    function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] bits);
        logic [CNT_W-1:0] sum;
        sum = {CNT_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum = sum + CNT_W'(bits[i]);
        end
        return sum;
    endfunction

    // Stage 1 state
    logic             s1_valid_r;
    logic [CNT_W-1:0] s1_cnt_r;
    logic             s1_mode_r;
    logic             s1_last_r;
    // Set while an accumulate-mode packet has started but not yet seen its last beat
    logic             pkt_open_r;

    // Stage 2 state
    logic [ACC_W-1:0] acc_r;
    logic             acc_sat_r;
    logic             out_valid_r;
    logic [ACC_W-1:0] out_count_r;
    logic             out_sat_r;

    // Combinational helpers
    logic             stall_s;
    logic             fire_s;
    logic             eff_mode_s;
    logic [ACC_W:0]   sum_wide_s;
    logic             sat_s;
    logic [ACC_W-1:0] next_acc_s;

    assign stall_s   = out_valid_r & ~out_ready;
    assign in_ready  = ~stall_s;
    assign fire_s    = in_valid & ~stall_s;
    assign out_valid = out_valid_r;
    assign out_count = out_count_r;
    assign out_sat   = out_sat_r;

    // Mode is taken from the input only on the first beat of a packet;
    // inside an open packet it is forced to accumulate.
    assign eff_mode_s = pkt_open_r | mode;

    // Saturating add of the stage-1 count into the running packet sum.
    always_comb begin
        sum_wide_s = {1'b0, acc_r} + (ACC_W + 1)'(s1_cnt_r);
        sat_s      = acc_sat_r | sum_wide_s[ACC_W];
        if (sat_s) begin
            next_acc_s = {ACC_W{1'b1}};
        end else begin
            next_acc_s = sum_wide_s[ACC_W-1:0];
        end
    end

    // Stage 1: capture the compressed count, tags and packet-open tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_cnt_r   <= {CNT_W{1'b0}};
            s1_mode_r  <= 1'b0;
            s1_last_r  <= 1'b0;
            pkt_open_r <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r <= fire_s;
            if (fire_s) begin
                s1_cnt_r   <= popcount(in_data);
                s1_mode_r  <= eff_mode_s;
                s1_last_r  <= in_last;
                pkt_open_r <= eff_mode_s & ~in_last;
            end else begin
                s1_cnt_r   <= s1_cnt_r;
                s1_mode_r  <= s1_mode_r;
                s1_last_r  <= s1_last_r;
                pkt_open_r <= pkt_open_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_cnt_r   <= s1_cnt_r;
            s1_mode_r  <= s1_mode_r;
            s1_last_r  <= s1_last_r;
            pkt_open_r <= pkt_open_r;
        end
    end

    // Stage 2: accumulator and registered result with saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= {ACC_W{1'b0}};
            acc_sat_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_count_r <= {ACC_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else if (!stall_s) begin
            if (s1_valid_r && !s1_mode_r) begin
                // Per-beat result, accumulator untouched
                out_valid_r <= 1'b1;
                out_count_r <= ACC_W'(s1_cnt_r);
                out_sat_r   <= 1'b0;
            end else if (s1_valid_r && s1_last_r) begin
                // Packet closes: present total and restart from zero
                out_valid_r <= 1'b1;
                out_count_r <= next_acc_s;
                out_sat_r   <= sat_s;
                acc_r       <= {ACC_W{1'b0}};
                acc_sat_r   <= 1'b0;
            end else if (s1_valid_r) begin
                // Mid-packet beat: accumulate silently
                out_valid_r <= 1'b0;
                acc_r       <= next_acc_s;
                acc_sat_r   <= sat_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
            out_count_r <= out_count_r;
            out_sat_r   <= out_sat_r;
            acc_r       <= acc_r;
            acc_sat_r   <= acc_sat_r;
        end
    end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 Parameter: N, default 16; number of input bits compressed per beat (N >= 2).
REQ-002 Parameter: ACC_W, default 8; accumulator/output width; ACC_W >= clog2(N+1).
REQ-003 Derived: CNT_W = clog2(N+1); width of a single-beat count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  N  bits to count (number of 1s).
REQ-009 in_last  input  1  final beat of an accumulate-mode packet.
REQ-010 mode  input  1  0 = per-beat count, 1 = accumulate across beats until in_last.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_count  output  ACC_W  result: ones count, zero-extended or accumulated.
REQ-014 out_sat  output  1  result saturated (accumulate mode only).

Function
REQ-015 Beat accepted ("fire") when in_valid & in_ready; result delivered when out_valid & out_ready.
REQ-016 Two pipeline stages: S1 registers the CNT_W popcount of in_data (compressor tree), plus mode/last tags; S2 holds the accumulator and output register.
REQ-017 Stall-all pipeline: stall = out_valid & ~out_ready; in_ready = ~stall; while stalled, S1, S2, accumulator and outputs hold.
REQ-018 Mode 0: beat fired at edge t gives out_valid=1 with out_count = popcount at edge t+2 (no stall); in_last ignored; out_sat=0.
REQ-019 Mode 1: each fired beat's count added to accumulator in S2; out_valid asserted only for the beat carrying in_last, 2 cycles after it fires, out_count = sum of all beats of the packet including the last.
REQ-020 Accumulator clears to 0 after the in_last result is presented, so next packet starts from 0; a 1-beat packet (in_last on first beat) returns its own count.
REQ-021 Saturation: if sum exceeds 2^ACC_W-1, out_count = 2^ACC_W-1 and out_sat=1 for that result; further beats of the packet do not wrap.
REQ-022 Mode latched at first beat of a packet (first fire after reset, after a mode-0 beat, or after an in_last beat); mode input ignored on later beats until in_last fires.
REQ-023 out_valid stays high and out_count/out_sat stable until out_ready; back-to-back results with out_ready=1 sustain one beat per cycle.
REQ-024 Idle cycles (no fire) inside a mode-1 packet hold accumulator; out_valid stays 0.
REQ-025 Simultaneous delivery and fire in the same cycle is legal and loses no data.
REQ-026 in_data with in_valid=0 has no effect.

Reset
REQ-027 rst asserted: immediately out_valid=0, out_count=0, out_sat=0, accumulator=0, S1 valid=0, mode latch cleared; in_ready=1 once stall clears (stall false during reset).
REQ-028 rst mid-packet or mid-stall discards all in-flight beats and partial sums; first fire after release starts a new packet.

Verification
REQ-029 N=16, ACC_W=8, mode=0, in_data=16'hFFFF then 16'h0001, out_ready=1 -> out_count=16 at t+2, 1 at t+3, out_sat=0.
REQ-030 Mode=1, beats 16'h00FF, 16'h0F0F, 16'hFFFF(last) -> single result out_count=32, out_valid only 2 cycles after last; next 1-beat packet 16'h0003(last) -> 2.
REQ-031 Mode=1, 17 beats of 16'hFFFF with last on 17th -> out_count=255, out_sat=1; next packet 16'h0001(last) -> 1, out_sat=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles with 3 mode-0 beats offered -> in_ready=0 while stalled, out_count held; on release, results delivered in order, none lost or duplicated.
REQ-033 Mode toggled 1->0 on beat 2 of a mode-1 packet -> ignored, packet completes as accumulation at in_last.
REQ-034 rst pulsed after 2 beats of a mode-1 packet -> outputs 0 immediately; new packet 16'h000F(last) -> out_count=4.
